// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store access sequencer between the execute-stage LSU
// and the data-memory port. It takes one request per transaction and issues
// word-aligned memory accesses with byte enables and lane-shifted store data.
// Word-crossing accesses are split into two memory transactions, and the
// load data from both is merged and then sign/zero-extended.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   lsu_valid/ready     request handshake; lsu_ready = FSM idle
//   lsu_we/size/unsigned/addr/wdata   request fields (wdata right-justified)
//   lsu_done/err/rdata  one-cycle completion pulse with status and load data
//   mem_req/gnt         memory request, held until granted
//   mem_addr/we/be/wdata  word-aligned access, lane-aligned store data
//   mem_rvalid/rdata/err  in-order response, one per grant
//
// state | meaning
// IDLE  | ready for a request; also the cycle lsu_done is pulsed
// REQ0  | first (or only) access requested, waiting for mem_gnt
// WAIT0 | first access granted, waiting for mem_rvalid
// REQ1  | upper word of a crossing access requested
// WAIT1 | upper word granted, waiting for mem_rvalid
module lsu_mem_ctrl #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT          = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Loaded at grant; expiry fires while the counter reads 1, so the error
  // pulse lands exactly TIMEOUT cycles after the grant.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'h1;
      2'b01:   return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic is_crossing(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && (off == 2'b11)) || ((size == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                               input logic uns);
    logic [31:0] res;
    case (size)
      2'b00:   res = {{24{raw[7] & ~uns}}, raw[7:0]};
      2'b01:   res = {{16{raw[15] & ~uns}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  state_t      state_q, state_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata0_q, rdata0_d;
  logic [TW-1:0] timer_q, timer_d;

  logic        mem_req_d, mem_we_d, lsu_done_d, lsu_err_d;
  logic [31:0] mem_addr_d, mem_wdata_d, lsu_rdata_d;
  logic [3:0]  mem_be_d;

  // First access lanes come straight from the request; the second access
  // is built later from the latched copy.
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  assign in_be    = size_mask(lsu_size) << lsu_addr[1:0];
  assign in_wdata = lsu_wdata << {lsu_addr[1:0], 3'b000};

  logic        cross_q;
  logic [3:0]  be_hi;
  logic [31:0] wdata_hi;
  assign cross_q  = is_crossing(size_q, addr_q[1:0]);
  assign be_hi    = 4'(({4'b0000, size_mask(size_q)} << addr_q[1:0]) >> 4);
  assign wdata_hi = wdata_q >> {3'd4 - {1'b0, addr_q[1:0]}, 3'b000};

  // Lower word is the first response; for single accesses the upper half is 0.
  logic [63:0] merge_src;
  logic [31:0] merged, load_ext;
  assign merge_src = (state_q == WAIT1) ? {mem_rdata, rdata0_q} : {32'h0, mem_rdata};
  assign merged    = 32'(merge_src >> {addr_q[1:0], 3'b000});
  assign load_ext  = extend_load(merged, size_q, uns_q);

  assign lsu_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    uns_d       = uns_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    lsu_done_d  = 1'b0;
    lsu_err_d   = lsu_err;
    lsu_rdata_d = lsu_rdata;
    case (state_q)
      IDLE: begin
        if (lsu_valid) begin
          we_d    = lsu_we;
          uns_d   = lsu_unsigned;
          size_d  = lsu_size;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          if ((lsu_size == 2'b11) ||
              (!ALLOW_MISALIGNED && is_crossing(lsu_size, lsu_addr[1:0]))) begin
            lsu_done_d  = 1'b1;
            lsu_err_d   = 1'b1;
            lsu_rdata_d = 32'h0;
          end else begin
            state_d     = REQ0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {lsu_addr[31:2], 2'b00};
            mem_we_d    = lsu_we;
            mem_be_d    = in_be;
            mem_wdata_d = in_wdata;
          end
        end
      end
      REQ0, REQ1: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          timer_d   = TIMER_LOAD;
          state_d   = (state_q == REQ0) ? WAIT0 : WAIT1;
        end
      end
      WAIT0, WAIT1: begin
        if (mem_rvalid) begin
          if (mem_err) begin
            state_d     = IDLE;
            lsu_done_d  = 1'b1;
            lsu_err_d   = 1'b1;
            lsu_rdata_d = 32'h0;
          end else if ((state_q == WAIT0) && cross_q) begin
            state_d     = REQ1;
            rdata0_d    = mem_rdata;
            mem_req_d   = 1'b1;
            mem_addr_d  = {addr_q[31:2], 2'b00} + 32'd4;
            mem_be_d    = be_hi;
            mem_wdata_d = wdata_hi;
          end else begin
            state_d     = IDLE;
            lsu_done_d  = 1'b1;
            lsu_err_d   = 1'b0;
            lsu_rdata_d = we_q ? 32'h0 : load_ext;
          end
        end else if ((TIMEOUT != 0) && (timer_q <= TW'(1))) begin
          state_d     = IDLE;
          lsu_done_d  = 1'b1;
          lsu_err_d   = 1'b1;
          lsu_rdata_d = 32'h0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata0_q  <= 32'h0;
      timer_q   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= 32'h0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      timer_q   <= timer_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      mem_we    <= mem_we_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      lsu_done  <= lsu_done_d;
      lsu_err   <= lsu_err_d;
      lsu_rdata <= lsu_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl. One instance allows misaligned
// accesses with a short timeout; a second instance disallows them.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        lsu_valid, lsu_we, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_ready, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        v2, ready2, done2, err2, req2, we2;
  logic [31:0] rdata2, addr2, wdata2;
  logic [3:0]  be2;

  lsu_mem_ctrl #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  lsu_mem_ctrl #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT(0)) dut_strict (
    .clk(clk), .rst(rst),
    .lsu_valid(v2), .lsu_ready(ready2), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(done2), .lsu_err(err2), .lsu_rdata(rdata2),
    .mem_req(req2), .mem_gnt(1'b0), .mem_addr(addr2), .mem_we(we2),
    .mem_be(be2), .mem_wdata(wdata2), .mem_rvalid(1'b0),
    .mem_rdata(32'h0), .mem_err(1'b0)
  );

  int n_chk = 0;
  int n_fail = 0;

  int          nreq, done_cyc, unstable;
  bit          acc_ok;
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_be [2];
  logic        r_we [2];
  logic [31:0] o_rdata;
  logic        o_err;

  // Presents one request in the current cycle and plays a memory that grants
  // after gnt_dly waiting cycles and answers the cycle after each grant.
  // Returns in the cycle lsu_done is seen (cycle count relative to accept).
  task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic err0, input int gnt_dly, input logic withhold);
    int dly;
    bit rv_pend, seen;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    nreq = 0; done_cyc = -1; unstable = 0; o_rdata = 'x; o_err = 'x;
    seen = 0; rv_pend = 0; dly = gnt_dly; a0 = 0; w0 = 0; b0 = 0;
    for (int i = 0; i < 2; i++) begin
      r_addr[i] = 'x; r_wdata[i] = 'x; r_be[i] = 'x; r_we[i] = 'x;
    end
    lsu_valid = 1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    acc_ok = lsu_ready;
    @(posedge clk); #1;
    lsu_valid = 0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
      if (lsu_done) begin
        done_cyc = cyc; o_rdata = lsu_rdata; o_err = lsu_err;
      end else begin
        if (rv_pend) begin
          rv_pend = 0;
          if (!withhold) begin
            mem_rvalid = 1;
            mem_rdata  = (nreq == 1) ? rd0 : rd1;
            mem_err    = (nreq == 1) && err0;
          end
        end
        if (mem_req) begin
          if (!seen) begin
            seen = 1; a0 = mem_addr; b0 = mem_be; w0 = mem_wdata;
          end else if (mem_addr !== a0 || mem_be !== b0 || mem_wdata !== w0) begin
            unstable++;
          end
          if (dly == 0) begin
            if (nreq < 2) begin
              r_addr[nreq] = mem_addr; r_be[nreq] = mem_be;
              r_wdata[nreq] = mem_wdata; r_we[nreq] = mem_we;
            end
            nreq++; mem_gnt = 1; rv_pend = 1; seen = 0; dly = gnt_dly;
          end else begin
            dly--;
          end
        end
        @(posedge clk); #1;
      end
    end
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({mem_req, mem_we, lsu_done, lsu_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, lsu_done, lsu_err}); end
    n_chk++; if ({mem_addr, mem_wdata, lsu_rdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, lsu_rdata}); end
    n_chk++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %h want 0", mem_be); end
    n_chk++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", lsu_ready); end
    rst = 0;
    @(posedge clk); #1;
    n_chk++; if ({lsu_ready, ready2, lsu_done} !== 3'b110) begin n_fail++; $display("FAIL reset_release: got %b want 110", {lsu_ready, ready2, lsu_done}); end
  endtask

  task automatic test_aligned_load;
    run_access(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    n_chk++; if (nreq !== 1) begin n_fail++; $display("FAIL lw_nreq: got %0d want 1", nreq); end
    n_chk++; if ({r_addr[0], r_be[0], r_we[0]} !== {32'h100, 4'hF, 1'b0}) begin n_fail++; $display("FAIL lw_req: got %h/%h/%b want 00000100/f/0", r_addr[0], r_be[0], r_we[0]); end
    n_chk++; if (done_cyc !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", done_cyc); end
    n_chk++; if ({o_rdata, o_err} !== {32'hDEADBEEF, 1'b0}) begin n_fail++; $display("FAIL lw_rdata: got %h err %b want deadbeef err 0", o_rdata, o_err); end
  endtask

  task automatic test_byte_load;
    run_access(0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 32'h0, 0, 0, 0);
    n_chk++; if ({r_addr[0], r_be[0]} !== {32'h100, 4'b1000}) begin n_fail++; $display("FAIL lb_req: got %h/%b want 00000100/1000", r_addr[0], r_be[0]); end
    n_chk++; if (o_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext: got %h want ffffff80", o_rdata); end
    run_access(0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 32'h0, 0, 0, 0);
    n_chk++; if ({o_rdata, done_cyc} !== {32'h00000080, 32'd3}) begin n_fail++; $display("FAIL lbu_zext: got %h cyc %0d want 00000080 cyc 3", o_rdata, done_cyc); end
  endtask

  task automatic test_store_cross;
    run_access(1, 2'b10, 0, 32'h102, 32'hAABBCCDD, 32'h0, 32'h0, 0, 0, 0);
    n_chk++; if (nreq !== 2) begin n_fail++; $display("FAIL sw_nreq: got %0d want 2", nreq); end
    n_chk++; if ({r_addr[0], r_be[0], r_wdata[0], r_we[0]} !== {32'h100, 4'b1100, 32'hCCDD0000, 1'b1}) begin n_fail++; $display("FAIL sw_req0: got %h/%b/%h/%b want 00000100/1100/ccdd0000/1", r_addr[0], r_be[0], r_wdata[0], r_we[0]); end
    n_chk++; if ({r_addr[1], r_be[1], r_wdata[1], r_we[1]} !== {32'h104, 4'b0011, 32'h0000AABB, 1'b1}) begin n_fail++; $display("FAIL sw_req1: got %h/%b/%h/%b want 00000104/0011/0000aabb/1", r_addr[1], r_be[1], r_wdata[1], r_we[1]); end
    n_chk++; if ({done_cyc, o_rdata, o_err} !== {32'd5, 32'h0, 1'b0}) begin n_fail++; $display("FAIL sw_done: got cyc %0d rdata %h err %b want cyc 5 rdata 0 err 0", done_cyc, o_rdata, o_err); end
    run_access(1, 2'b00, 0, 32'h101, 32'h12345678, 32'h0, 32'h0, 0, 0, 0);
    n_chk++; if ({r_be[0], r_wdata[0], done_cyc} !== {4'b0010, 32'h34567800, 32'd3}) begin n_fail++; $display("FAIL sb_lane: got %b/%h cyc %0d want 0010/34567800 cyc 3", r_be[0], r_wdata[0], done_cyc); end
  endtask

  task automatic test_half_cross;
    run_access(0, 2'b01, 0, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 0, 3, 0);
    n_chk++; if ({nreq, unstable} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL lh_hold: got nreq %0d unstable %0d want 2 0", nreq, unstable); end
    n_chk++; if ({r_addr[0], r_be[0], r_addr[1], r_be[1]} !== {32'h100, 4'b1000, 32'h104, 4'b0001}) begin n_fail++; $display("FAIL lh_reqs: got %h/%b %h/%b want 00000100/1000 00000104/0001", r_addr[0], r_be[0], r_addr[1], r_be[1]); end
    n_chk++; if ({done_cyc, o_rdata} !== {32'd11, 32'hFFFF8811}) begin n_fail++; $display("FAIL lh_slow: got cyc %0d rdata %h want cyc 11 ffff8811", done_cyc, o_rdata); end
    run_access(0, 2'b01, 1, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 0, 0, 0);
    n_chk++; if ({done_cyc, o_rdata} !== {32'd5, 32'h00008811}) begin n_fail++; $display("FAIL lhu_cross: got cyc %0d rdata %h want cyc 5 00008811", done_cyc, o_rdata); end
    run_access(0, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 32'hAB000000, 32'h000000CD, 0, 0, 0);
    n_chk++; if ({r_addr[0], r_addr[1]} !== {32'hFFFFFFFC, 32'h0}) begin n_fail++; $display("FAIL lh_wrap_addr: got %h %h want fffffffc 00000000", r_addr[0], r_addr[1]); end
    n_chk++; if (o_rdata !== 32'hFFFFCDAB) begin n_fail++; $display("FAIL lh_wrap_data: got %h want ffffcdab", o_rdata); end
  endtask

  task automatic test_mem_err;
    run_access(0, 2'b10, 0, 32'h0FE, 32'h0, 32'h12345678, 32'h9ABCDEF0, 1, 0, 0);
    n_chk++; if ({nreq, done_cyc} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL err_abort: got nreq %0d cyc %0d want 1 3", nreq, done_cyc); end
    n_chk++; if ({r_addr[0], r_be[0], o_err} !== {32'h0FC, 4'b1100, 1'b1}) begin n_fail++; $display("FAIL err_flag: got %h/%b err %b want 000000fc/1100 err 1", r_addr[0], r_be[0], o_err); end
  endtask

  task automatic test_strict;
    lsu_we = 0; lsu_size = 2'b10; lsu_unsigned = 0; lsu_addr = 32'h0FE; v2 = 1;
    @(posedge clk); #1;
    v2 = 0;
    n_chk++; if ({done2, err2, req2} !== 3'b110) begin n_fail++; $display("FAIL strict_done: got %b want 110", {done2, err2, req2}); end
    @(posedge clk); #1;
    n_chk++; if ({done2, req2, ready2} !== 3'b001) begin n_fail++; $display("FAIL strict_after: got %b want 001", {done2, req2, ready2}); end
  endtask

  task automatic test_timeout;
    run_access(0, 2'b10, 0, 32'h300, 32'h0, 32'h0, 32'h0, 0, 0, 1);
    n_chk++; if ({nreq, done_cyc, o_err} !== {32'd1, 32'd5, 1'b1}) begin n_fail++; $display("FAIL timeout: got nreq %0d cyc %0d err %b want 1 5 1", nreq, done_cyc, o_err); end
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 0;
    n_chk++; if ({lsu_done, lsu_err, lsu_ready} !== 3'b011) begin n_fail++; $display("FAIL late_rvalid: got %b want 011", {lsu_done, lsu_err, lsu_ready}); end
  endtask

  task automatic test_back_to_back;
    run_access(0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    n_chk++; if ({nreq, done_cyc, o_err} !== {32'd0, 32'd1, 1'b1}) begin n_fail++; $display("FAIL illegal_size: got nreq %0d cyc %0d err %b want 0 1 1", nreq, done_cyc, o_err); end
    run_access(0, 2'b10, 0, 32'h100, 32'h0, 32'hCAFEF00D, 32'h0, 0, 0, 0);
    n_chk++; if (acc_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", acc_ok); end
    n_chk++; if ({done_cyc, o_rdata, o_err} !== {32'd3, 32'hCAFEF00D, 1'b0}) begin n_fail++; $display("FAIL b2b_load: got cyc %0d rdata %h err %b want 3 cafef00d 0", done_cyc, o_rdata, o_err); end
  endtask

  task automatic test_reset_mid;
    bit saw;
    lsu_we = 0; lsu_size = 2'b10; lsu_unsigned = 0; lsu_addr = 32'h200; lsu_valid = 1;
    @(posedge clk); #1;
    lsu_valid = 0;
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got %b want 1", mem_req); end
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    n_chk++; if ({lsu_ready, mem_req} !== 2'b00) begin n_fail++; $display("FAIL rstmid_wait: got %b want 00", {lsu_ready, mem_req}); end
    rst = 1;
    #1;
    n_chk++; if ({mem_req, lsu_ready, lsu_done, lsu_rdata} !== {3'b010, 32'h0}) begin n_fail++; $display("FAIL rstmid_async: got %b rdata %h want 010 rdata 0", {mem_req, lsu_ready, lsu_done}, lsu_rdata); end
    @(posedge clk); #1;
    rst = 0;
    saw = 0;
    mem_rvalid = 1; mem_rdata = 32'h55555555;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_rvalid = 0;
      if (lsu_done || mem_req) saw = 1;
    end
    n_chk++; if ({saw, lsu_ready} !== 2'b01) begin n_fail++; $display("FAIL rstmid_quiet: got %b want 01", {saw, lsu_ready}); end
    run_access(0, 2'b10, 0, 32'h100, 32'h0, 32'h0BADF00D, 32'h0, 0, 0, 0);
    n_chk++; if ({done_cyc, o_rdata} !== {32'd3, 32'h0BADF00D}) begin n_fail++; $display("FAIL rstmid_resume: got cyc %0d rdata %h want 3 0badf00d", done_cyc, o_rdata); end
  endtask

  initial begin
    rst = 1; v2 = 0;
    lsu_valid = 0; lsu_we = 0; lsu_size = 0; lsu_unsigned = 0; lsu_addr = 0; lsu_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    test_reset();
    test_aligned_load();
    test_byte_load();
    test_store_cross();
    test_half_cross();
    test_mem_err();
    test_strict();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
